// File: rtl/rs232_uart_if.sv
// rs232_uart_if: request/done control port between the system bus wrapper and the UART.
interface rs232_uart_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic        ctrl_done;
  logic [31:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  modport master (output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat, input ctrl_rdat, ctrl_done);
  modport slave (input ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat, output ctrl_rdat, ctrl_done);
endinterface

// File: rtl/rs232_uart.sv
// rs232_uart: memory-mapped 8N1 UART with one-byte TX/RX holding registers.
module rs232_uart #(
  parameter int CLOCK_FREQ_HZ = 50000000,
  parameter int BAUD = 115200
) (
  input  logic        clk,
  input  logic        reset,
  rs232_uart_if.slave ctrl,
  input  logic        rxd,
  output logic        txd
);
  localparam int DIV = CLOCK_FREQ_HZ / BAUD;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
  state_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, sync_q;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
  logic rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic armed_q, armed_d, done_q, done_d;
  logic [31:0] rdat_q, rdat_d;
  logic go, rd, wr_data, rd_data, rd_stat, tx_end, tx_load, rx_end, rx_in, rx_ok, rx_bad;
  logic unused_bits;
  assign unused_bits = ^{ctrl.ctrl_addr[31:4], ctrl.ctrl_addr[1:0], ctrl.ctrl_wdat[31:8]};
  assign go = armed_q && (ctrl.ctrl_wr || ctrl.ctrl_rd);
  assign rd = go && !ctrl.ctrl_wr;
  assign wr_data = go && ctrl.ctrl_wr && ctrl.ctrl_addr[3:2] == 2'd0;
  assign rd_data = rd && ctrl.ctrl_addr[3:2] == 2'd0;
  assign rd_stat = rd && ctrl.ctrl_addr[3:2] == 2'd1;
  assign tx_end = tx_cnt_q == LAST;
  assign rx_end = rx_cnt_q == LAST;
  assign rx_in = sync_q[1];
  // A busy transmitter stalls a DATA write until the stop bit's final edge.
  assign tx_load = wr_data && (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_end));
  assign txd = tx_st_q == S_START ? 1'b0 : tx_st_q == S_DATA ? tx_sh_q[0] : 1'b1;
  assign ctrl.ctrl_done = done_q;
  assign ctrl.ctrl_rdat = rdat_q;
  always_comb begin
    done_d = go && (!wr_data || tx_load);
    armed_d = done_d ? 1'b0 : (!ctrl.ctrl_wr && !ctrl.ctrl_rd) ? 1'b1 : armed_q;
    rdat_d = !rd ? rdat_q :
             ctrl.ctrl_addr[3:2] == 2'd0 ? {24'b0, rx_byte_q} :
             ctrl.ctrl_addr[3:2] == 2'd1 ? {28'b0, frame_err_q, overrun_q, tx_st_q == S_IDLE, rx_valid_q} :
             32'b0;
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    case (tx_st_q)
      S_IDLE: tx_cnt_d = '0;
      S_START: if (tx_end) begin
        tx_st_d = S_DATA;
        tx_bit_d = '0;
      end
      S_DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d = tx_bit_q == 3'd7 ? S_STOP : S_DATA;
      end
      default: if (tx_end) tx_st_d = S_IDLE;
    endcase
    if (tx_load) begin
      tx_st_d = S_START;
      tx_sh_d = ctrl.ctrl_wdat[7:0];
      tx_cnt_d = '0;
    end
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_ok = 1'b0;
    rx_bad = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        rx_st_d = (sync_q[2] && !rx_in) ? S_START : S_IDLE;
      end
      S_START: if (rx_cnt_q == HALF) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = rx_in ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_end) begin
        rx_sh_d = {rx_in, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d = rx_bit_q == 3'd7 ? S_STOP : S_DATA;
      end
      default: if (rx_end) begin
        rx_ok = rx_in;
        rx_bad = !rx_in;
        rx_st_d = S_IDLE;
      end
    endcase
    // A frame landing during a DATA read keeps rx_valid and does not count as overrun.
    rx_byte_d = rx_ok ? rx_sh_q : rx_byte_q;
    rx_valid_d = rx_ok ? 1'b1 : rd_data ? 1'b0 : rx_valid_q;
    overrun_d = (rx_ok && rx_valid_q && !rd_data) ? 1'b1 : rd_data ? 1'b0 : overrun_q;
    frame_err_d = rx_bad ? 1'b1 : rd_stat ? 1'b0 : frame_err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q <= S_IDLE;
      rx_st_q <= S_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_byte_q <= '0;
      rx_valid_q <= 1'b0;
      overrun_q <= 1'b0;
      frame_err_q <= 1'b0;
      sync_q <= 3'b111;
      armed_q <= 1'b1;
      done_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      tx_st_q <= tx_st_d;
      rx_st_q <= rx_st_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      overrun_q <= overrun_d;
      frame_err_q <= frame_err_d;
      sync_q <= {sync_q[1:0], rxd};
      armed_q <= armed_d;
      done_q <= done_d;
      rdat_q <= rdat_d;
    end
  end
endmodule

// File: tb/tb_rs232_uart.sv
// tb_rs232_uart: directed bench for rs232_uart at DIV=10.
module tb_rs232_uart;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic txd;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] tx_bytes[$];
  logic tx_stops[$];
  int tx_starts[$];
  rs232_uart_if bus();
  rs232_uart #(.CLOCK_FREQ_HZ(1000000), .BAUD(100000)) dut (
    .clk(clk), .reset(reset), .ctrl(bus), .rxd(rxd), .txd(txd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask
  // Decodes txd frames by sampling mid-bit on falling clock edges.
  initial forever begin
    @(negedge clk);
    if (!reset && txd === 1'b0) begin
      logic [7:0] b;
      int s;
      s = cyc;
      repeat (4) @(negedge clk);
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          b[i] = txd;
        end
        repeat (10) @(negedge clk);
        tx_bytes.push_back(b);
        tx_stops.push_back(txd);
        tx_starts.push_back(s);
      end
    end
  end
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] d, input int extra,
                      output logic [31:0] rdat, output int nd, output int dcyc);
    nd = 0;
    dcyc = -1;
    rdat = '0;
    @(negedge clk);
    bus.ctrl_wr = wr;
    bus.ctrl_rd = !wr;
    bus.ctrl_addr = {28'h2000000, a};
    bus.ctrl_wdat = {24'h0, d};
    for (int k = 0; k < 400 && nd == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.ctrl_done) begin
        nd++;
        dcyc = cyc;
        rdat = bus.ctrl_rdat;
      end
    end
    repeat (extra) begin
      @(posedge clk);
      #1;
      if (bus.ctrl_done) nd++;
    end
    @(negedge clk);
    bus.ctrl_wr = 1'b0;
    bus.ctrl_rd = 1'b0;
    @(posedge clk);
    #1;
    if (bus.ctrl_done) nd++;
  endtask
  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int nd, dc;
    xfer(1'b0, a, 8'h00, 0, r, nd, dc);
    check({tag, "_done"}, nd, 1);
    check(tag, r, exp);
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (10) @(negedge clk);
    end
    rxd = stop;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  initial begin
    logic [31:0] r;
    int nd, dc, dc1;
    bus.ctrl_wr = 1'b0;
    bus.ctrl_rd = 1'b0;
    bus.ctrl_addr = '0;
    bus.ctrl_wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_done", bus.ctrl_done, 0);
    check("rst_rdat", bus.ctrl_rdat, 0);
    @(negedge clk);
    reset = 1'b0;
    rd_check("rst_status", 4'h4, 32'h2);
    xfer(1'b1, 4'h0, 8'h55, 2, r, nd, dc);
    check("tx_done_once", nd, 1);
    repeat (110) @(negedge clk);
    check("tx_frames", tx_bytes.size(), 1);
    check("tx_byte", tx_bytes[0], 8'h55);
    check("tx_stop", tx_stops[0], 1);
    check("tx_start_edge", tx_starts[0], dc);
    xfer(1'b1, 4'h0, 8'h55, 0, r, nd, dc1);
    rd_check("b2b_status1", 4'h4, 32'h0);
    xfer(1'b1, 4'h0, 8'hA3, 0, r, nd, dc);
    check("b2b_done", nd, 1);
    check("b2b_done_delay", dc - dc1, 100);
    rd_check("b2b_status2", 4'h4, 32'h0);
    repeat (110) @(negedge clk);
    check("b2b_frames", tx_bytes.size(), 3);
    check("b2b_byte1", tx_bytes[1], 8'h55);
    check("b2b_byte2", tx_bytes[2], 8'hA3);
    check("b2b_stop2", tx_stops[2], 1);
    check("b2b_gap", tx_starts[2] - tx_starts[1], 100);
    check("b2b_start_at_done", tx_starts[2], dc);
    rd_check("tx_idle_status", 4'h4, 32'h2);
    send_rx(8'h3C, 1'b1);
    rd_check("rx_status", 4'h4, 32'h3);
    rd_check("rx_data", 4'h0, 32'h3C);
    rd_check("rx_status_clr", 4'h4, 32'h2);
    xfer(1'b1, 4'h8, 8'hFF, 0, r, nd, dc);
    check("wr_reg2_done", nd, 1);
    check("rdat_hold", bus.ctrl_rdat, 32'h2);
    rd_check("rd_reg3", 4'hC, 32'h0);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd_check("ovr_status", 4'h4, 32'h7);
    rd_check("ovr_data", 4'h0, 32'h22);
    rd_check("ovr_status_clr", 4'h4, 32'h2);
    send_rx(8'h44, 1'b1);
    send_rx(8'h99, 1'b0);
    rd_check("ferr_status", 4'h4, 32'hB);
    rd_check("ferr_status_clr", 4'h4, 32'h3);
    rd_check("ferr_data", 4'h0, 32'h44);
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    rd_check("glitch_status", 4'h4, 32'h2);
    send_rx(8'hC5, 1'b1);
    rd_check("glitch_rx_status", 4'h4, 32'h3);
    rd_check("glitch_rx_data", 4'h0, 32'hC5);
    xfer(1'b1, 4'h0, 8'h00, 0, r, nd, dc);
    repeat (20) @(negedge clk);
    check("midframe_txd_low", txd, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midframe_reset_txd", txd, 1);
    @(negedge clk);
    reset = 1'b0;
    rd_check("midframe_status", 4'h4, 32'h2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs232_uart.md
# rs232_uart

Memory-mapped 8N1 UART peripheral for the picorv32 system bus, decoded by the system at 0x2000_0000–0x2000_000F. Firmware writes transmit bytes and reads received bytes and status through a simple request/done control port. One serial transmitter and one serial receiver, each with a one-byte holding register. The bus wrapper holds a request until it sees `ctrl_done`.

## Interface
- `CLOCK_FREQ_HZ`, 50000000, system clock frequency.
- `BAUD`, 115200, line rate.
- Derived constant: `DIV = CLOCK_FREQ_HZ / BAUD` (integer truncation), clocks per bit; minimum 4.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: reset, synchronous and active-high. One clock; reset is synchronous and active-high.
- `ctrl_wr` in 1: write request, held high until after done.
- `ctrl_rd` in 1: read request, held high until after done.
- `ctrl_addr` in 32: byte address; only bits [3:2] decoded.
- `ctrl_wdat` in 32: write data; bits [7:0] used.
- `ctrl_rdat` out 32: read data, registered.
- `ctrl_done` out 1: single-cycle completion pulse.
- `rxd` in 1: serial input, asynchronous.
- `txd` out 1: serial output, idle high.

## Operation
Register map, selected by `ctrl_addr[3:2]`:
- **0, DATA.**
  - Write: queue `ctrl_wdat[7:0]` for transmit.
  - Read: `{24'b0, rx_byte}`; clears `rx_valid` and `overrun`.
- **1, STATUS.** Read returns:
  - bit0 `rx_valid`
  - bit1 `tx_ready` (transmitter idle)
  - bit2 `overrun`
  - bit3 `frame_err`
  - other bits 0.
  - Reading STATUS clears `frame_err`. Writes to STATUS are ignored but still complete.
- **2, 3.** Reads return 0; writes are ignored; both complete normally.

Request handling:
- A transaction starts when the unit is armed and `ctrl_wr` or `ctrl_rd` is high. If both are high, write wins.
- After issuing `ctrl_done`, the unit disarms. It re-arms only after a cycle in which both `ctrl_wr` and `ctrl_rd` are low.
- Therefore a request held for several cycles after done executes exactly once.

Transmitter:
- States: IDLE, START, DATA(8), STOP.
- A DATA write loads the shift register and enters START.
- Frame on `txd`: start bit low for DIV cycles, then 8 data bits LSB-first for DIV cycles each, then stop bit high for DIV cycles, then IDLE.
- `tx_ready` is 1 only in IDLE.

Receiver:
- `rxd` passes through a 2-flop synchronizer.
- In IDLE, a high-to-low transition starts a frame.
- At DIV/2 cycles the start bit is re-sampled; if it is high, the unit returns to IDLE with no flags changed.
- Data bits are then sampled every DIV cycles, LSB-first. The stop bit is sampled DIV cycles after bit 7.
- Stop bit high: the byte goes to `rx_byte` and `rx_valid` is set to 1. If `rx_valid` was already 1, `overrun` is also set to 1 and the new byte overwrites the old.
- Stop bit low: the byte is discarded and `frame_err` is set to 1.
- After the stop sample, the receiver returns to IDLE and waits for the next falling edge.

## Timing
- Reset values:
  - Outputs: `txd`=1, `ctrl_done`=0, `ctrl_rdat`=0.
  - Internal: `rx_valid`=0, `overrun`=0, `frame_err`=0; both FSMs IDLE; unit armed.
- Reset mid-frame: both FSMs abort and `txd`=1 from the next cycle. Reset has priority over every other event.
- Read latency:
  - Request first sampled high at edge N → `ctrl_rdat` is valid and `ctrl_done`=1 after edge N.
  - `ctrl_rdat` holds its value until the next read.
- Write to DATA with transmitter idle: latency is 1, as for reads. `txd` goes low after the same edge N.
- Write to DATA with transmitter busy: the write stalls. `ctrl_done` pulses at the edge where the transmitter would enter IDLE, and the new byte loads at that same edge. Start bit follows the stop bit back-to-back.
- `ctrl_done` is high for exactly one cycle per transaction.
- Frame completes while DATA is being read: the new byte wins. `rx_valid` stays 1 and `overrun` is not set; the read returns the old byte.
- Synchronizer delay: 2 cycles from `rxd` pin to the start-bit detector.

## Test plan
Bench parameters: `CLOCK_FREQ_HZ`=1000000, `BAUD`=100000, so DIV=10.

1. **Reset.** Assert reset 3 cycles → `txd`=1, `ctrl_done`=0, `ctrl_rdat`=0; STATUS read returns 0x2.
2. **Transmit.** Write DATA 0x55 with request held 3 cycles → one `ctrl_done`. `txd` shows start 0, bits 1,0,1,0,1,0,1,0, stop 1, each 10 cycles (100 cycles total). Exactly one frame.
3. **Back-to-back write.** Write 0xA3 while 0x55 is still shifting → `ctrl_done` delayed until the 0x55 stop bit ends. 0xA3 frame follows with no idle gap; STATUS bit1=0 during both frames.
4. **Receive.** Drive 8N1 frame 0x3C on `rxd` → STATUS = 0x3. DATA read returns 0x3C; a following STATUS read returns 0x2.
5. **Overrun and framing error.**
   - Receive 0x11 then 0x22 without reading → STATUS bit2=1; DATA read returns 0x22.
   - Frame with stop bit 0 → bit3=1, `rx_valid` unchanged.
6. **Glitch.** 3-cycle low pulse on `rxd` → no flags set; a proper frame afterwards is received correctly.
